keypad_scan_decoder: RTL and testbench

//  Front end of the calculator. Drives the 4x4 keypad column lines, samples the row lines and debounces presses.

---
 rtl/keypad_scan_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_decoder.sv
// 4x4 keypad front end: column scan, row synchronizer, scan-level debounce FSM
// and calculator-class decode of each accepted press.
module keypad_scan_decoder #(
   parameter int unsigned SCAN_DIV       = 2000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic       key_valid,
   output logic       key_held,
   output logic [3:0] key_code,
   output logic       is_digit,
   output logic       is_op,
   output logic       is_equals,
   output logic       is_clear,
   output logic [3:0] digit,
   output logic [1:0] op
);

   localparam int unsigned DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W   = 4;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]   DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);
   localparam logic               DEB_SINGLE = (DEBOUNCE_SCANS <= 1);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} stateT;

   logic [3:0]         rowsMeta, rowsSync;
   logic [DWELL_W-1:0] dwellCnt;
   logic [1:0]         colIdx;
   logic               sampleNow, scanDone;
   logic [3:0]         rowLow;
   logic [2:0]         colHits, sumHits;
   logic [1:0]         colRow;
   logic [1:0]         hitCount;
   logic [3:0]         hitCode, scanCode;
   logic               scanNone, scanOne;

   stateT              state, stateNext;
   logic [3:0]         cand, candNext, codeNext;
   logic [CNT_W-1:0]   debCnt, cntNext, cntInc;
   logic               validNext, heldNext;

   logic [1:0]         codeRow, codeCol;
   logic               decDigitF, decOpF, decEqF, decClrF;
   logic [3:0]         decDigit;
   logic [1:0]         decOp;

   // Two-stage synchronizer; rows idle high so reset to all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         rowsMeta <= 4'hF;
         rowsSync <= 4'hF;
      end else begin
         rowsMeta <= rows;
         rowsSync <= rowsMeta;
      end
   end

   assign sampleNow = (dwellCnt == DWELL_LAST);
   assign scanDone  = sampleNow && (colIdx == 2'd3);

   // Column dwell counter and one-hot-low column driver
   always_ff @(posedge clk) begin
      if (rst) begin
         dwellCnt <= '0;
         colIdx   <= 2'd0;
         cols     <= 4'b1110;
      end else if (sampleNow) begin
         dwellCnt <= '0;
         colIdx   <= colIdx + 2'd1;
         cols     <= {cols[2:0], cols[3]};
      end else begin
         dwellCnt <= dwellCnt + DWELL_W'(1);
      end
   end

   // Hits in the column being sampled, and the row of the lowest one
   always_comb begin
      rowLow  = ~rowsSync;
      colHits = {2'b00, rowLow[0]} + {2'b00, rowLow[1]} + {2'b00, rowLow[2]} + {2'b00, rowLow[3]};
      colRow  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (rowLow[i]) colRow = 2'(i);
      end
      sumHits  = {1'b0, hitCount} + colHits;
      scanCode = (hitCount == 2'd0) ? {colRow, colIdx} : hitCode;
      scanNone = (sumHits == 3'd0);
      scanOne  = (sumHits == 3'd1);
   end

   // Per-scan accumulator; hitCount saturates at 2 meaning "two or more"
   always_ff @(posedge clk) begin
      if (rst) begin
         hitCount <= 2'd0;
         hitCode  <= 4'd0;
      end else if (sampleNow) begin
         if (colIdx == 2'd3) begin
            hitCount <= 2'd0;
            hitCode  <= 4'd0;
         end else begin
            hitCount <= (sumHits >= 3'd2) ? 2'd2 : sumHits[1:0];
            if (hitCount == 2'd0) hitCode <= {colRow, colIdx};
         end
      end
   end

   // Debounce FSM, evaluated once per completed scan
   always_comb begin
      stateNext = state;
      candNext  = cand;
      cntNext   = debCnt;
      codeNext  = key_code;
      validNext = 1'b0;
      cntInc    = debCnt + CNT_W'(1);
      if (scanDone) begin
         case (state)
            IDLE: begin
               if (scanOne) begin
                  candNext = scanCode;
                  cntNext  = CNT_W'(1);
                  if (DEB_SINGLE) begin
                     stateNext = PRESSED;
                     codeNext  = scanCode;
                     validNext = 1'b1;
                  end else begin
                     stateNext = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (scanOne && (scanCode == cand)) begin
                  cntNext = cntInc;
                  if (cntInc >= DEB_TARGET) begin
                     stateNext = PRESSED;
                     codeNext  = cand;
                     validNext = 1'b1;
                  end
               end else if (scanOne) begin
                  candNext = scanCode;
                  cntNext  = CNT_W'(1);
               end else begin
                  stateNext = IDLE;
               end
            end
            PRESSED: begin
               if (scanNone) begin
                  cntNext   = CNT_W'(1);
                  stateNext = DEB_SINGLE ? IDLE : RELEASE;
               end
            end
            RELEASE: begin
               if (scanNone) begin
                  cntNext = cntInc;
                  if (cntInc >= DEB_TARGET) stateNext = IDLE;
               end else begin
                  stateNext = PRESSED;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
      heldNext = (stateNext == PRESSED) || (stateNext == RELEASE);
   end

   // Calculator class of the code about to be latched
   always_comb begin
      codeRow   = codeNext[3:2];
      codeCol   = codeNext[1:0];
      decDigitF = 1'b0;
      decOpF    = 1'b0;
      decEqF    = 1'b0;
      decClrF   = 1'b0;
      decDigit  = 4'd0;
      decOp     = 2'd0;
      if (codeCol == 2'd3) begin
         decOpF = 1'b1;
         decOp  = codeRow;
      end else if (codeRow == 2'd3) begin
         case (codeCol)
            2'd0:    decClrF   = 1'b1;
            2'd1:    decDigitF = 1'b1;
            default: decEqF    = 1'b1;
         endcase
      end else begin
         decDigitF = 1'b1;
         decDigit  = ({2'b00, codeRow} * 4'd3) + {2'b00, codeCol} + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cand      <= 4'd0;
         debCnt    <= '0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         is_digit  <= 1'b0;
         is_op     <= 1'b0;
         is_equals <= 1'b0;
         is_clear  <= 1'b0;
         digit     <= 4'd0;
         op        <= 2'd0;
      end else begin
         state     <= stateNext;
         cand      <= candNext;
         debCnt    <= cntNext;
         key_code  <= codeNext;
         key_valid <= validNext;
         key_held  <= heldNext;
         if (validNext) begin
            is_digit  <= decDigitF;
            is_op     <= decOpF;
            is_equals <= decEqF;
            is_clear  <= decClrF;
            digit     <= decDigit;
            op        <= decOp;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Bench for keypad_scan_decoder: keypad matrix model, directed scan table,
// reset-during-debounce sequence and random scans against a scan-level model.
module tb_keypad_scan_decoder;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DS       = 3;
   localparam int          SCAN_LEN = 4 * SCAN_DIV;
   localparam int PH_IDLE = 0, PH_DEB = 1, PH_DOWN = 2, PH_REL = 3;

   logic       clk, rst;
   logic [3:0] rows, cols, key_code, digit;
   logic       key_valid, key_held, is_digit, is_op, is_equals, is_clear;
   logic [1:0] op;
   logic [15:0] keys;

   int vectors = 0;
   int fails   = 0;
   bit heldNow;
   bit anyDir;

   // Scan-level reference state
   int         mPhase, mCnt;
   logic [3:0] mCand, mCode;
   bit         mAny;

   string layout = "123A456B789C*0#D";

   typedef struct {
      logic [15:0] keys;
      bit          expValid;
      bit          expHeld;
      logic [3:0]  expCode;
   } vecT;
   vecT vecs[$];

   keypad_scan_decoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
      .clk(clk), .rst(rst), .rows(rows), .cols(cols),
      .key_valid(key_valid), .key_held(key_held), .key_code(key_code),
      .is_digit(is_digit), .is_op(is_op), .is_equals(is_equals), .is_clear(is_clear),
      .digit(digit), .op(op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A pressed key pulls its row low while its column is driven low
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
   end

   function automatic vecT mk(input logic [15:0] k, input bit v, input bit h, input logic [3:0] c);
      vecT t;
      t.keys = k; t.expValid = v; t.expHeld = h; t.expCode = c;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mPhase = PH_IDLE; mCnt = 0; mCand = 4'd0; mCode = 4'd0; mAny = 1'b0;
   endtask

   // One full scan with a given set of pressed keys
   task automatic modelScan(input logic [15:0] mask, output bit v);
      int n;
      logic [3:0] code;
      n = $countones(mask);
      code = 4'd0;
      for (int i = 0; i < 16; i++) if (mask[i]) code = 4'(i);
      v = 1'b0;
      if (mPhase == PH_IDLE || mPhase == PH_DEB) begin
         if (n != 1) mPhase = PH_IDLE;
         else if (mPhase == PH_DEB && code == mCand) mCnt++;
         else begin mCand = code; mCnt = 1; mPhase = PH_DEB; end
         if (mPhase == PH_DEB && mCnt >= DS) begin
            mPhase = PH_DOWN; mCode = mCand; mAny = 1'b1; v = 1'b1;
         end
      end else if (n != 0) begin
         mPhase = PH_DOWN;
      end else begin
         mCnt   = (mPhase == PH_DOWN) ? 1 : mCnt + 1;
         mPhase = (mCnt >= DS) ? PH_IDLE : PH_REL;
      end
   endtask

   // Starts and ends #1 after the edge that opens a scan (col0, dwell 0)
   task automatic runScan(input logic [15:0] mask);
      logic [3:0] expCols;
      keys = mask;
      for (int i = 0; i < SCAN_LEN; i++) begin
         @(negedge clk);
         expCols = 4'hF ^ (4'b0001 << (i / SCAN_DIV));
         check("cols", 32'(cols), 32'(expCols));
         if (i > 0) check("key_valid_idle", 32'(key_valid), 32'h0);
         check("key_held_level", 32'(key_held), 32'(heldNow));
         @(posedge clk); #1;
      end
   endtask

   task automatic endCheck(input string tag, input bit eValid, input bit eHeld,
                           input logic [3:0] eCode, input bit eAny);
      byte ch;
      bit eDig, eOpF, eEq, eClr;
      logic [3:0] eDigit;
      logic [1:0] eOp;
      ch     = layout[eCode];
      eDig   = eAny && ch >= "0" && ch <= "9";
      eOpF   = eAny && ch >= "A" && ch <= "D";
      eEq    = eAny && ch == "#";
      eClr   = eAny && ch == "*";
      eDigit = eDig ? 4'(ch - "0") : 4'd0;
      eOp    = eOpF ? 2'(ch - "A") : 2'd0;
      check({tag, " key_valid"}, 32'(key_valid), 32'(eValid));
      check({tag, " key_held"},  32'(key_held),  32'(eHeld));
      check({tag, " key_code"},  32'(key_code),  32'(eCode));
      check({tag, " is_digit"},  32'(is_digit),  32'(eDig));
      check({tag, " is_op"},     32'(is_op),     32'(eOpF));
      check({tag, " is_equals"}, 32'(is_equals), 32'(eEq));
      check({tag, " is_clear"},  32'(is_clear),  32'(eClr));
      check({tag, " digit"},     32'(digit),     32'(eDigit));
      check({tag, " op"},        32'(op),        32'(eOp));
   endtask

   initial begin
      bit v;
      int curKey;
      logic [15:0] mask;

      // Bit index of a key = row*4 + col
      // idle scans
      vecs.push_back(mk(16'h0000, 0, 0, 4'h0));
      vecs.push_back(mk(16'h0000, 0, 0, 4'h0));
      // '7' held four scans, then released
      vecs.push_back(mk(16'h0100, 0, 0, 4'h0));
      vecs.push_back(mk(16'h0100, 0, 0, 4'h0));
      vecs.push_back(mk(16'h0100, 1, 1, 4'h8));
      vecs.push_back(mk(16'h0100, 0, 1, 4'h8));
      vecs.push_back(mk(16'h0000, 0, 1, 4'h8));
      vecs.push_back(mk(16'h0000, 0, 1, 4'h8));
      vecs.push_back(mk(16'h0000, 0, 0, 4'h8));
      // '5' bouncing: present, absent, present x3
      vecs.push_back(mk(16'h0020, 0, 0, 4'h8));
      vecs.push_back(mk(16'h0000, 0, 0, 4'h8));
      vecs.push_back(mk(16'h0020, 0, 0, 4'h8));
      vecs.push_back(mk(16'h0020, 0, 0, 4'h8));
      vecs.push_back(mk(16'h0020, 1, 1, 4'h5));
      vecs.push_back(mk(16'h0000, 0, 1, 4'h5));
      vecs.push_back(mk(16'h0000, 0, 1, 4'h5));
      vecs.push_back(mk(16'h0000, 0, 0, 4'h5));
      // 'C', multi during debounce, then 'C' accepted and '1' added while held
      vecs.push_back(mk(16'h0800, 0, 0, 4'h5));
      vecs.push_back(mk(16'h0801, 0, 0, 4'h5));
      vecs.push_back(mk(16'h0800, 0, 0, 4'h5));
      vecs.push_back(mk(16'h0800, 0, 0, 4'h5));
      vecs.push_back(mk(16'h0800, 1, 1, 4'hB));
      vecs.push_back(mk(16'h0801, 0, 1, 4'hB));
      vecs.push_back(mk(16'h0801, 0, 1, 4'hB));
      vecs.push_back(mk(16'h0000, 0, 1, 4'hB));
      vecs.push_back(mk(16'h0000, 0, 1, 4'hB));
      vecs.push_back(mk(16'h0000, 0, 0, 4'hB));
      // '#' with a release bounce, then '*'
      vecs.push_back(mk(16'h4000, 0, 0, 4'hB));
      vecs.push_back(mk(16'h4000, 0, 0, 4'hB));
      vecs.push_back(mk(16'h4000, 1, 1, 4'hE));
      vecs.push_back(mk(16'h0000, 0, 1, 4'hE));
      vecs.push_back(mk(16'h4000, 0, 1, 4'hE));
      vecs.push_back(mk(16'h0000, 0, 1, 4'hE));
      vecs.push_back(mk(16'h0000, 0, 1, 4'hE));
      vecs.push_back(mk(16'h0000, 0, 0, 4'hE));
      vecs.push_back(mk(16'h1000, 0, 0, 4'hE));
      vecs.push_back(mk(16'h1000, 0, 0, 4'hE));
      vecs.push_back(mk(16'h1000, 1, 1, 4'hC));
      vecs.push_back(mk(16'h0000, 0, 1, 4'hC));
      vecs.push_back(mk(16'h0000, 0, 1, 4'hC));
      vecs.push_back(mk(16'h0000, 0, 0, 4'hC));

      keys = 16'h0000;
      rst  = 1'b1;
      heldNow = 1'b0;
      anyDir  = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset cols", 32'(cols), 32'(4'b1110));
      endCheck("reset", 1'b0, 1'b0, 4'h0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         runScan(vecs[i].keys);
         modelScan(vecs[i].keys, v);
         anyDir |= vecs[i].expValid;
         endCheck($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expHeld, vecs[i].expCode, anyDir);
         heldNow = vecs[i].expHeld;
      end

      // '9' reaches cnt=2, then rst lands mid-scan
      runScan(16'h0400);
      endCheck("rst9 s1", 1'b0, 1'b0, 4'hC, 1'b1);
      runScan(16'h0400);
      endCheck("rst9 s2", 1'b0, 1'b0, 4'hC, 1'b1);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst9 cols", 32'(cols), 32'(4'b1110));
      endCheck("rst9 after", 1'b0, 1'b0, 4'h0, 1'b0);
      modelReset();
      heldNow = 1'b0;
      runScan(16'h0400);
      endCheck("rst9 r1", 1'b0, 1'b0, 4'h0, 1'b0);
      runScan(16'h0400);
      endCheck("rst9 r2", 1'b0, 1'b0, 4'h0, 1'b0);
      runScan(16'h0400);
      endCheck("rst9 r3", 1'b1, 1'b1, 4'hA, 1'b1);
      heldNow = 1'b1;
      for (int i = 0; i < 3; i++) begin
         runScan(16'h0000);
         endCheck($sformatf("rst9 rel%0d", i), 1'b0, i < 2, 4'hA, 1'b1);
         heldNow = (i < 2);
      end
      for (int i = 0; i < 3; i++) modelScan(16'h0400, v);
      for (int i = 0; i < 3; i++) modelScan(16'h0000, v);

      // Random scans: a mostly-stable key with gaps and occasional extra keys
      curKey = $urandom_range(0, 15);
      for (int s = 0; s < 90; s++) begin
         int p;
         p = $urandom_range(0, 9);
         if (p < 3)      mask = 16'h0000;
         else if (p < 8) mask = 16'h0001 << curKey;
         else            mask = (16'h0001 << curKey) | (16'h0001 << $urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) curKey = $urandom_range(0, 15);
         runScan(mask);
         modelScan(mask, v);
         endCheck($sformatf("rnd%0d", s), v, (mPhase == PH_DOWN) || (mPhase == PH_REL), mCode, mAny);
         heldNow = (mPhase == PH_DOWN) || (mPhase == PH_REL);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
